// File: rtl/platform_scheduler.sv
// platform_scheduler: per-frame sweep of the platform table doing the landing test,
// scroll and respawn through a single read port and a single write port.
module platform_scheduler #(
   parameter int NUM_PLAT = 16,
   parameter int SCREEN_H = 480,
   parameter int X_LIMIT  = 400,
   parameter int DOODLE_W = 20,
   parameter int HIT_BAND = 8
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        enable,
   input  logic [9:0]  doodle_x,
   input  logic [9:0]  doodle_y,
   input  logic        doodle_falling,
   input  logic [7:0]  scroll_amt,
   output logic [3:0]  rd_idx,
   input  logic [8:0]  rd_x,
   input  logic [8:0]  rd_y,
   input  logic [8:0]  rd_w,
   output logic        wr_en,
   output logic [3:0]  wr_idx,
   output logic [8:0]  wr_x,
   output logic [8:0]  wr_y,
   output logic        wr_respawn,
   output logic        hit,
   output logic [3:0]  hit_idx,
   output logic [8:0]  hit_y,
   output logic        busy,
   output logic        done,
   output logic [15:0] frame_count,
   output logic        overrun
);
   typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, DONE} state_t;
   state_t state, state_nx;
   logic [1:0]  rs;
   logic        rst_n;
   logic [2:0]  fs;
   logic        fr_edge, start, last, pending, hflag, hit_now, respawn, resp, fall, fb;
   logic [3:0]  slot, hidx;
   logic [8:0]  hy, lv, lx, px;
   logic [9:0]  dx, dy, ny, nw;
   logic [7:0]  scr;
   logic [15:0] lfsr;

   // reset asserts asynchronously but releases on a clock edge
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) rs <= '0;
      else rs <= {rs[0], 1'b1};
   assign rst_n = rs[1];

   assign fr_edge = fs[1] & ~fs[2];
   assign start   = state == IDLE && enable && (fr_edge || pending);
   assign last    = slot == 4'(NUM_PLAT - 1);
   assign hit_now = fall && dx + 10'(DOODLE_W) > {1'b0, rd_x} && dx < {1'b0, rd_x} + {1'b0, rd_w}
                    && dy >= {1'b0, rd_y} && dy < {1'b0, rd_y} + 10'(HIT_BAND);
   assign ny      = {1'b0, rd_y} + {2'b0, scr};
   assign nw      = ny - 10'(SCREEN_H);
   assign respawn = ny >= 10'(SCREEN_H);
   assign lv      = lfsr[8:0];
   assign lx      = lv < 9'(X_LIMIT) ? lv : lv - 9'(X_LIMIT);
   assign fb      = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   assign rd_idx     = slot;
   assign wr_idx     = slot;
   assign wr_en      = state == WRITE;
   assign wr_respawn = wr_en & resp;
   assign busy       = state != IDLE;
   assign done       = state == DONE;
   assign hit        = done & hflag;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? READ : IDLE;
         READ:    state_nx = EVAL;
         EVAL:    state_nx = WRITE;
         WRITE:   state_nx = last ? DONE : READ;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         fs <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
         slot <= '0;
         hflag <= 1'b0;
         hidx <= '0;
         hy <= '0;
         hit_idx <= '0;
         hit_y <= '0;
         wr_x <= '0;
         wr_y <= '0;
         resp <= 1'b0;
         scr <= '0;
         dx <= '0;
         dy <= '0;
         fall <= 1'b0;
         frame_count <= '0;
         lfsr <= 16'hACE1;
      end else begin
         state <= state_nx;
         fs <= {fs[1:0], frame_clk};
         if (start) begin
            scr <= scroll_amt;
            dx <= doodle_x;
            dy <= doodle_y;
            fall <= doodle_falling;
            pending <= 1'b0;
            slot <= '0;
            hflag <= 1'b0;
         end else if (!enable) pending <= 1'b0;
         else if (fr_edge && busy) begin
            if (pending) overrun <= 1'b1;
            else pending <= 1'b1;
         end
         if (state == EVAL) begin
            wr_x <= respawn ? lx : rd_x;
            wr_y <= respawn ? nw[8:0] : ny[8:0];
            resp <= respawn;
            if (respawn) lfsr <= {fb, lfsr[15:1]};
            if (hit_now && !hflag) begin
               hflag <= 1'b1;
               hidx <= slot;
               hy <= rd_y;
            end
         end
         if (state == WRITE && !last) slot <= slot + 4'd1;
         if (state == WRITE && last && hflag) begin
            hit_idx <= hidx;
            hit_y <= hy;
         end
         if (done) frame_count <= frame_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_platform_scheduler.sv
// tb_platform_scheduler: directed scenarios against a behavioural platform register file.
module tb_platform_scheduler;
   logic        Clk = 0, Reset = 0, frame_clk = 0, enable = 0;
   logic [9:0]  doodle_x = 0, doodle_y = 0;
   logic        doodle_falling = 0;
   logic [7:0]  scroll_amt = 0;
   logic [3:0]  rd_idx, wr_idx, hit_idx;
   logic [8:0]  rd_x = 0, rd_y = 0, rd_w = 0;
   logic        wr_en, wr_respawn, hit, busy, done, overrun;
   logic [8:0]  wr_x, wr_y, hit_y;
   logic [15:0] frame_count;

   int total = 0, bad = 0;
   logic [8:0] px[16], py[16], pw[16], ex_x[16], ex_y[16];
   logic       ex_r[16];

   platform_scheduler dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
      .doodle_x(doodle_x), .doodle_y(doodle_y), .doodle_falling(doodle_falling),
      .scroll_amt(scroll_amt), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_respawn(wr_respawn),
      .hit(hit), .hit_idx(hit_idx), .hit_y(hit_y), .busy(busy), .done(done),
      .frame_count(frame_count), .overrun(overrun)
   );

   always #10 Clk = ~Clk;

   always @(posedge Clk) begin
      rd_x <= px[rd_idx];
      rd_y <= py[rd_idx];
      rd_w <= pw[rd_idx];
   end

   int nw = 0, nbusy = 0, ndone = 0, nhit = 0, cyc = 0, last_done = 0, gap = 0, start_cyc = 0, done_off = 0;
   logic [3:0] l_idx[256];
   logic [8:0] l_x[256], l_y[256];
   logic       l_r[256];
   logic [3:0] h_idx = 0;
   logic [8:0] h_y = 0;
   logic       h_done = 0, busy_q = 0;

   always @(negedge Clk) begin
      cyc++;
      if (wr_en) begin
         l_idx[nw & 255] = wr_idx;
         l_x[nw & 255] = wr_x;
         l_y[nw & 255] = wr_y;
         l_r[nw & 255] = wr_respawn;
         nw++;
      end
      if (busy) nbusy++;
      if (busy && !busy_q) begin
         gap = cyc - last_done;
         start_cyc = cyc;
      end
      busy_q = busy;
      if (done) begin
         ndone++;
         last_done = cyc;
         done_off = cyc - start_cyc;
      end
      if (hit) begin
         nhit++;
         h_idx = hit_idx;
         h_y = hit_y;
         h_done = done;
      end
   end

   task automatic pulse();
      @(posedge Clk) #1 frame_clk = 1;
      repeat (4) @(posedge Clk);
      #1 frame_clk = 0;
      repeat (4) @(posedge Clk);
   endtask

   task automatic wait_dones(input int n, input int base);
      int k = 0;
      while (ndone < base + n && k < 400) begin
         @(negedge Clk);
         k++;
      end
      total++;
      if (ndone < base + n) begin
         bad++;
         $display("FAIL sweep_timeout done_pulses=%0d want=%0d", ndone - base, n);
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic run_frame();
      int b0 = ndone;
      pulse();
      wait_dones(1, b0);
   endtask

   task automatic check_writes(input int w0, input string tag);
      total++;
      if (nw - w0 !== 16) begin
         bad++;
         $display("FAIL %s_write_count got=%0d want=16", tag, nw - w0);
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if ({l_idx[(w0 + i) & 255], l_x[(w0 + i) & 255], l_y[(w0 + i) & 255], l_r[(w0 + i) & 255]}
             !== {4'(i), ex_x[i], ex_y[i], ex_r[i]}) begin
            bad++;
            $display("FAIL %s_slot%0d got idx=%0d x=%0d y=%0d r=%0d want idx=%0d x=%0d y=%0d r=%0d", tag, i,
                     l_idx[(w0 + i) & 255], l_x[(w0 + i) & 255], l_y[(w0 + i) & 255], l_r[(w0 + i) & 255],
                     i, ex_x[i], ex_y[i], ex_r[i]);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      total++;
      if ({busy, done, wr_en, wr_respawn, hit, overrun} !== 6'b0) begin
         bad++;
         $display("FAIL %s_flags got=%b want=000000", tag, {busy, done, wr_en, wr_respawn, hit, overrun});
      end
      total++;
      if (frame_count !== 16'd0) begin
         bad++;
         $display("FAIL %s_frame_count got=%0d want=0", tag, frame_count);
      end
      total++;
      if ({rd_idx, wr_idx, hit_idx, wr_x, wr_y, hit_y} !== 39'd0) begin
         bad++;
         $display("FAIL %s_buses got rd=%0d wi=%0d hi=%0d wx=%0d wy=%0d hy=%0d want all 0", tag,
                  rd_idx, wr_idx, hit_idx, wr_x, wr_y, hit_y);
      end
   endtask

   // LFSR from 16'hACE1: low nine bits 225, 112, 312, 412 (wraps to 12)
   task automatic fill_wrap();
      for (int i = 0; i < 16; i++) begin
         px[i] = 9'(i * 20);
         py[i] = 9'd100;
         pw[i] = 9'd30;
         ex_x[i] = 9'(i * 20);
         ex_y[i] = 9'd112;
         ex_r[i] = 1'b0;
      end
      py[1] = 9'd467; ex_y[1] = 9'd479;
      py[3] = 9'd475; ex_y[3] = 9'd7; ex_x[3] = 9'd225; ex_r[3] = 1'b1;
      py[5] = 9'd475; ex_y[5] = 9'd7; ex_x[5] = 9'd112; ex_r[5] = 1'b1;
      py[8] = 9'd475; ex_y[8] = 9'd7; ex_x[8] = 9'd312; ex_r[8] = 1'b1;
      py[12] = 9'd468; ex_y[12] = 9'd0; ex_x[12] = 9'd12; ex_r[12] = 1'b1;
      scroll_amt = 8'd12;
   endtask

   task automatic test_reset();
      Reset = 0;
      repeat (3) @(posedge Clk);
      #1 check_zero("reset");
      Reset = 1;
      repeat (4) @(posedge Clk);
   endtask

   task automatic test_scroll();
      int w0, b0;
      for (int i = 0; i < 16; i++) begin
         px[i] = 9'(i * 20);
         py[i] = 9'd100;
         pw[i] = 9'd30;
         ex_x[i] = 9'(i * 20);
         ex_y[i] = 9'd110;
         ex_r[i] = 1'b0;
      end
      scroll_amt = 8'd10;
      enable = 1;
      w0 = nw;
      b0 = nbusy;
      run_frame();
      check_writes(w0, "scroll");
      total++;
      if (nbusy - b0 !== 49) begin
         bad++;
         $display("FAIL scroll_busy_cycles got=%0d want=49", nbusy - b0);
      end
      total++;
      if (done_off !== 48) begin
         bad++;
         $display("FAIL scroll_done_latency got=%0d want=48", done_off);
      end
      total++;
      if (frame_count !== 16'd1) begin
         bad++;
         $display("FAIL scroll_frame_count got=%0d want=1", frame_count);
      end
   endtask

   task automatic test_wrap();
      int w0;
      fill_wrap();
      w0 = nw;
      run_frame();
      check_writes(w0, "wrap");
   endtask

   task automatic test_landing();
      int w0, h0;
      for (int i = 0; i < 16; i++) begin
         px[i] = 9'd300;
         py[i] = 9'd50;
         pw[i] = 9'd20;
      end
      px[2] = 9'd90; pw[2] = 9'd40; py[2] = 9'd200;
      px[9] = 9'd90; pw[9] = 9'd40; py[9] = 9'd200;
      for (int i = 0; i < 16; i++) begin
         ex_x[i] = px[i];
         ex_y[i] = py[i];
         ex_r[i] = 1'b0;
      end
      scroll_amt = 8'd0;
      doodle_falling = 1;
      doodle_x = 10'd100;
      doodle_y = 10'd203;
      w0 = nw;
      h0 = nhit;
      run_frame();
      check_writes(w0, "noscroll");
      total++;
      if ({nhit - h0, h_done} !== {32'd1, 1'b1}) begin
         bad++;
         $display("FAIL land_hit_pulse got=%0d with_done=%b want=1 with_done=1", nhit - h0, h_done);
      end
      total++;
      if ({h_idx, h_y} !== {4'd2, 9'd200}) begin
         bad++;
         $display("FAIL land_hit_slot got idx=%0d y=%0d want idx=2 y=200", h_idx, h_y);
      end
      doodle_falling = 0;
      h0 = nhit;
      run_frame();
      total++;
      if (nhit - h0 !== 0) begin
         bad++;
         $display("FAIL land_not_falling got=%0d hits want=0", nhit - h0);
      end
      total++;
      if ({hit_idx, hit_y} !== {4'd2, 9'd200}) begin
         bad++;
         $display("FAIL land_hold got idx=%0d y=%0d want idx=2 y=200", hit_idx, hit_y);
      end
      doodle_falling = 1;
      doodle_y = 10'd208;
      h0 = nhit;
      run_frame();
      total++;
      if (nhit - h0 !== 0) begin
         bad++;
         $display("FAIL land_band_edge got=%0d hits want=0", nhit - h0);
      end
      total++;
      if (frame_count !== 16'd5) begin
         bad++;
         $display("FAIL land_frame_count got=%0d want=5", frame_count);
      end
      doodle_falling = 0;
   endtask

   task automatic test_overrun();
      int b0 = ndone;
      logic [15:0] fc0 = frame_count;
      pulse();
      pulse();
      pulse();
      wait_dones(2, b0);
      total++;
      if (gap !== 2) begin
         bad++;
         $display("FAIL overrun_restart_gap got=%0d want=2", gap);
      end
      repeat (80) @(negedge Clk);
      total++;
      if (ndone - b0 !== 2) begin
         bad++;
         $display("FAIL overrun_sweeps got=%0d want=2", ndone - b0);
      end
      total++;
      if ({overrun, frame_count} !== {1'b1, fc0 + 16'd2}) begin
         bad++;
         $display("FAIL overrun_state got ovr=%b fc=%0d want ovr=1 fc=%0d", overrun, frame_count, fc0 + 16'd2);
      end
   endtask

   task automatic test_disable();
      int b0 = nbusy, w0 = nw;
      logic [15:0] fc0 = frame_count;
      enable = 0;
      pulse();
      repeat (60) @(negedge Clk);
      total++;
      if ({nbusy - b0, nw - w0} !== 64'd0) begin
         bad++;
         $display("FAIL disable_activity got busy=%0d writes=%0d want 0 0", nbusy - b0, nw - w0);
      end
      total++;
      if (frame_count !== fc0) begin
         bad++;
         $display("FAIL disable_frame_count got=%0d want=%0d", frame_count, fc0);
      end
      enable = 1;
   endtask

   task automatic test_reset_mid();
      int w0, k = 0;
      fill_wrap();
      pulse();
      while (!(wr_en && wr_idx == 4'd7) && k < 100) begin
         @(negedge Clk);
         k++;
      end
      total++;
      if (!(wr_en && wr_idx == 4'd7)) begin
         bad++;
         $display("FAIL midreset_reach got wr_en=%b idx=%0d want wr_en=1 idx=7", wr_en, wr_idx);
      end
      #1 Reset = 0;
      #1 check_zero("midreset");
      w0 = nw;
      repeat (5) @(negedge Clk);
      total++;
      if (nw - w0 !== 0) begin
         bad++;
         $display("FAIL midreset_writes got=%0d want=0", nw - w0);
      end
      Reset = 1;
      repeat (4) @(negedge Clk);
      w0 = nw;
      run_frame();
      check_writes(w0, "reseed");
      total++;
      if (frame_count !== 16'd1) begin
         bad++;
         $display("FAIL reseed_frame_count got=%0d want=1", frame_count);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         px[i] = 0;
         py[i] = 0;
         pw[i] = 0;
      end
      test_reset();
      test_scroll();
      test_wrap();
      test_landing();
      test_overrun();
      test_disable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
